// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell with a registered borrow,
// LSB first, followed by an optional serial two's-complement pass to yield |A-B| and a minus flag.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_neg,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SUB, NEG, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, r_sr;
  logic [CW-1:0]    cnt;
  logic             bc;  // borrow during SUB, carry during NEG

  logic             a0, b0, r0, d, borrow_n, neg_bit, carry_n, last;
  logic [WIDTH-1:0] r_sub, r_neg;

  always_comb begin
    a0       = a_sr[0];
    b0       = b_sr[0];
    r0       = r_sr[0];
    d        = a0 ^ b0 ^ bc;
    borrow_n = (~a0 & b0) | (~(a0 ^ b0) & bc);
    neg_bit  = ~r0 ^ bc;
    carry_n  = ~r0 & bc;
    r_sub    = {d, r_sr[WIDTH-1:1]};
    r_neg    = {neg_bit, r_sr[WIDTH-1:1]};
    last     = (cnt == LAST);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state  <= IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      r_sr   <= '0;
      cnt    <= '0;
      bc     <= 1'b0;
      o_diff <= '0;
      o_neg  <= 1'b0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          o_done <= 1'b0;
          if (i_start) begin
            a_sr   <= i_a;
            b_sr   <= i_b;
            bc     <= 1'b0;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= SUB;
          end else begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        SUB: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          r_sr <= r_sub;
          bc   <= borrow_n;
          cnt  <= cnt + 1'b1;
          if (last) begin
            if (borrow_n) begin
              // Wrapped result: negate it serially to get the magnitude.
              cnt   <= '0;
              bc    <= 1'b1;
              state <= NEG;
            end else begin
              o_diff <= r_sub;
              o_neg  <= 1'b0;
              o_done <= 1'b1;
              o_busy <= 1'b0;
              state  <= DONE;
            end
          end
        end
        NEG: begin
          r_sr <= r_neg;
          bc   <= carry_n;
          cnt  <= cnt + 1'b1;
          if (last) begin
            o_diff <= r_neg;
            o_neg  <= 1'b1;
            o_done <= 1'b1;
            o_busy <= 1'b0;
            state  <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
